spw_rx_packet_assembler: RTL

Downstream consumer of the SpaceWire ulight core's receive FIFO (`datarx_flag` / `read_rx_fifo_en` / `f_empty_rx`). It drains 9-bit received characters, strips EOP/EEP markers, and presents packet bytes on a valid/ready byte stream. The final byte of each packet carries `m_last` and an error flag. It also enforces a maximum packet length and keeps packet and error counters for the host side.

---
 rtl/spw_rx_pkt_pkg.sv | 17 +
 rtl/spw_rx_packet_assembler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spw_rx_pkt_pkg.sv
// spw_rx_pkt_pkg
//   Shared definitions for the SpaceWire receive packet assembler:
//   assembler state encoding, the EOP/EEP control codes and the bit
//   position of the control flag in the 9-bit FIFO word.
package spw_rx_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

  localparam logic [7:0] SPW_EOP  = 8'h00;
  localparam logic [7:0] SPW_EEP  = 8'h01;
  localparam int         CTRL_BIT = 8;

endpackage

// File: rtl/spw_rx_packet_assembler.sv
// spw_rx_packet_assembler
//   Drains the SpaceWire RX FIFO, strips EOP/EEP markers and presents the
//   packet bytes on a valid/ready byte stream. One byte is held back so the
//   end-of-packet marker can be attached to it as m_last/m_err. Packets
//   longer than MAX_PKT_LEN are cut at MAX_PKT_LEN bytes (last byte flagged
//   err) and the remainder up to the next marker is discarded.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | between packets, no byte held back
//   HOLD    | one byte held in pend, waiting for the next character
//   DISCARD | packet truncated, dropping data until EOP/EEP
//
// Ports
//   ppll_100_MHZ    system clock (FIFO read side clock)
//   reset_spw       synchronous active-high reset
//   f_empty_rx      RX FIFO empty
//   datarx_flag     FIFO read data, valid the cycle after read_rx_fifo_en
//   read_rx_fifo_en FIFO read strobe
//   m_data/m_valid/m_ready/m_last/m_err  output byte stream
//   pkt_len         bytes emitted so far in the current packet
//   pkt_count       packets delivered (wraps)
//   err_count       packets delivered with m_err (wraps)
module spw_rx_packet_assembler
  import spw_rx_pkt_pkg::*;
#(
  parameter int MAX_PKT_LEN = 256,
  parameter int LEN_W       = 16
) (
  input  logic             ppll_100_MHZ,
  input  logic             reset_spw,
  input  logic             f_empty_rx,
  input  logic [8:0]       datarx_flag,
  output logic             read_rx_fifo_en,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             m_err,
  output logic [LEN_W-1:0] pkt_len,
  output logic [LEN_W-1:0] pkt_count,
  output logic [LEN_W-1:0] err_count
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_PKT_LEN);

  rx_state_e  state, state_nxt;
  logic       rd_inflight;
  logic [7:0] pend;

  logic is_ctrl, is_eop, at_limit, out_stall, last_hs;
  logic load, ld_last, ld_err, pend_we, len_inc, len_clr;

  assign is_ctrl   = datarx_flag[CTRL_BIT];
  assign is_eop    = is_ctrl && (datarx_flag[7:0] == SPW_EOP);
  assign at_limit  = ({1'b0, pkt_len} + (LEN_W+1)'(1)) == MAX_LEN;
  assign out_stall = m_valid && !m_ready;
  assign last_hs   = m_valid && m_ready && m_last;

  // Reads are spaced two cycles apart and never issued under a stall, so a
  // captured character always finds the output register free.
  assign read_rx_fifo_en = !reset_spw && !f_empty_rx && !rd_inflight && !out_stall;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ld_last   = 1'b0;
    ld_err    = 1'b0;
    pend_we   = 1'b0;
    len_inc   = 1'b0;
    len_clr   = 1'b0;
    if (rd_inflight) begin
      case (state)
        ST_IDLE: begin
          // A marker here closes an empty packet, which is simply dropped.
          if (!is_ctrl) begin
            pend_we   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          load = 1'b1;
          if (!is_ctrl) begin
            if (at_limit) begin
              ld_last   = 1'b1;
              ld_err    = 1'b1;
              state_nxt = ST_DISCARD;
            end else begin
              pend_we = 1'b1;
              len_inc = 1'b1;
            end
          end else begin
            ld_last   = 1'b1;
            ld_err    = !is_eop;
            len_clr   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (is_ctrl) begin
            len_clr   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ppll_100_MHZ) begin
    if (reset_spw) begin
      state       <= ST_IDLE;
      rd_inflight <= 1'b0;
      pend        <= 8'h00;
      m_valid     <= 1'b0;
      m_data      <= 8'h00;
      m_last      <= 1'b0;
      m_err       <= 1'b0;
      pkt_len     <= '0;
      pkt_count   <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= read_rx_fifo_en;

      if (pend_we) pend <= datarx_flag[7:0];

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= pend;
        m_last  <= ld_last;
        m_err   <= ld_err;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (len_clr || last_hs) pkt_len <= '0;
      else if (len_inc)       pkt_len <= pkt_len + 1'b1;

      if (last_hs) begin
        pkt_count <= pkt_count + 1'b1;
        if (m_err) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
